// File: rtl/outport_uart_tx.sv
// outport_uart_tx
//   Captures every CPU outport write into a small circular FIFO and sends the
//   low DATA_W bits of each entry as an 8N1-style UART frame on tx
//   (start bit, LSB-first data, stop bit).
//   Optional build macro: OUTPORT_UART_TX_PARITY_EN inserts an even-parity
//   bit between the last data bit and the stop bit.
//   Back-to-back frames: the stop bit's last tick pops the next entry, so
//   there is no idle gap between consecutive frames.
module outport_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_W       = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [31:0]                   wr_data,
    input  logic                          clear_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef OUTPORT_UART_TX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              overflow_reg;
    logic [DATA_W-1:0] head;

    // Serializer state
    logic [2:0]        state_reg,  state_next;
    logic [TW-1:0]     tick_reg,   tick_next;
    logic [BW-1:0]     bit_reg,    bit_next;
    logic [DATA_W-1:0] shift_reg,  shift_next;
    logic              tx_reg,     tx_next;
`ifdef OUTPORT_UART_TX_PARITY_EN
    logic              parity_reg, parity_next;
`endif

    logic              pop;
    logic              push;
    logic              ovf_set;
    logic              tick_last;
    logic              fifo_full;
    logic              fifo_empty;

    // Only the low DATA_W bits of the bus are transmitted.
    logic              unused_hi_bits;
    assign unused_hi_bits = ^wr_data[31:DATA_W];

    assign fifo_full  = (count_reg == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign head       = mem[rd_ptr_reg];
    assign tick_last  = (tick_reg == TW'(CLKS_PER_BIT - 1));

    // A pop frees a slot in the same cycle, so a write while full still lands.
    assign push    = wr_en && (!fifo_full || pop);
    assign ovf_set = wr_en && fifo_full && !pop;

    // Occupancy update: push and pop together leave the count unchanged
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // FIFO data array; contents need no reset because pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= wr_data[DATA_W-1:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
            if (ovf_set) begin
                overflow_reg <= 1'b1;
            end else if (clear_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // Frame sequencing: next state, bit timing and FIFO pop decisions
    always_comb begin
        state_next  = state_reg;
        tick_next   = tick_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        pop         = 1'b0;
`ifdef OUTPORT_UART_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_next  = head;
                    tick_next   = '0;
                    state_next  = ST_START;
`ifdef OUTPORT_UART_TX_PARITY_EN
                    parity_next = ^head;
`endif
                end
            end
            ST_START: begin
                if (tick_last) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = ST_DATA;
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            ST_DATA: begin
                if (tick_last) begin
                    tick_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BW'(DATA_W - 1)) begin
`ifdef OUTPORT_UART_TX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
`ifdef OUTPORT_UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_last) begin
                    tick_next  = '0;
                    state_next = ST_STOP;
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
`endif
            ST_STOP: begin
                if (tick_last) begin
                    tick_next = '0;
                    if (!fifo_empty) begin
                        pop         = 1'b1;
                        shift_next  = head;
                        state_next  = ST_START;
`ifdef OUTPORT_UART_TX_PARITY_EN
                        parity_next = ^head;
`endif
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    tick_next = tick_reg + TW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                tick_next  = '0;
            end
        endcase
    end

    // Line level for the upcoming state, registered so tx never glitches
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START:  tx_next = 1'b0;
            ST_DATA:   tx_next = shift_next[0];
`ifdef OUTPORT_UART_TX_PARITY_EN
            ST_PARITY: tx_next = parity_next;
`endif
            default:   tx_next = 1'b1;
        endcase
    end

    // Serializer registers; reset aborts any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            tick_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
`ifdef OUTPORT_UART_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            tick_reg   <= tick_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
`ifdef OUTPORT_UART_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    assign tx         = tx_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign full       = fifo_full;
    assign empty      = fifo_empty;
    assign fifo_count = count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed testbench for outport_uart_tx (CLKS_PER_BIT=4, DATA_W=8, FIFO_DEPTH=8).
// Follows OUTPORT_UART_TX_PARITY_EN to choose the expected frame layout.
module tb_outport_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int DW    = 8;
`ifdef OUTPORT_UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * CPB;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        clear_ovf;
    logic        tx;
    logic        busy;
    logic        full;
    logic        empty;
    logic [3:0]  fifo_count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    outport_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH),
        .DATA_W      (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .clear_ovf (clear_ovf),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .empty     (empty),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Expected line level for bit slot k of a frame carrying byte b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef OUTPORT_UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 32'h0;
        clear_ovf = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits for a start bit, then samples each bit slot at its centre.
    // Returns with the time aligned to where the next frame would begin.
    task automatic capture_frame(output logic [7:0] d, output logic par,
                                 output logic stp, output bit to);
        int n;
        n   = 0;
        to  = 1'b0;
        d   = 8'h00;
        par = 1'b0;
        stp = 1'b0;
        while (tx !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) begin
            to = 1'b1;
        end else begin
            repeat (CPB / 2) tick();
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) tick();
                d[i] = tx;
            end
`ifdef OUTPORT_UART_TX_PARITY_EN
            repeat (CPB) tick();
            par = tx;
`endif
            repeat (CPB) tick();
            stp = tx;
            repeat (CPB / 2) tick();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 32'h0;
        clear_ovf = 1'b0;
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset = 1'b0;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        b = 8'hA5;
        do_reset();
        wr_data = 32'h0000_00A5;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL e0_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL e0_busy: got %b expected 0", busy); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL e0_count: got %0d expected 1", fifo_count); end
        for (int c = 0; c < FRAME; c++) begin
            tick();
            checks++;
            if (tx !== frame_bit(b, c / CPB)) begin
                errors++;
                $display("FAIL single_tx cycle %0d: got %b expected %b", c, tx, frame_bit(b, c / CPB));
            end
            if (c == 0) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_start: got %b expected 1", busy); end
                checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty_start: got %b expected 1", empty); end
            end
        end
        tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_end_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_end_empty: got %b expected 1", empty); end
        $display("single frame A5 sent, %0d cycles", FRAME);
    endtask

    task automatic test_back_to_back();
        logic cap [3*FRAME];
        logic [7:0] bytes [3];
        int peak;
        int f;
        int k;
        bytes[0] = 8'h41;
        bytes[1] = 8'h42;
        bytes[2] = 8'h43;
        do_reset();
        wr_en   = 1'b1;
        wr_data = 32'h41;
        tick();
        peak = fifo_count;
        wr_data = 32'h42;
        tick();
        cap[0] = tx;
        if (fifo_count > peak) peak = fifo_count;
        wr_data = 32'h43;
        tick();
        cap[1] = tx;
        if (fifo_count > peak) peak = fifo_count;
        wr_en = 1'b0;
        for (int c = 2; c < 3 * FRAME; c++) begin
            tick();
            cap[c] = tx;
            if (fifo_count > peak) peak = fifo_count;
        end
        for (int c = 0; c < 3 * FRAME; c++) begin
            f = c / FRAME;
            k = (c % FRAME) / CPB;
            checks++;
            if (cap[c] !== frame_bit(bytes[f], k)) begin
                errors++;
                $display("FAIL b2b_tx cycle %0d: got %b expected %b", c, cap[c], frame_bit(bytes[f], k));
            end
        end
        checks++; if (peak !== 2) begin errors++; $display("FAIL b2b_peak: got %0d expected 2", peak); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_end_busy: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_end_empty: got %b expected 1", empty); end
        $display("back-to-back 41 42 43 sent, fifo peak %0d", peak);
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic par;
        logic stp;
        bit   to;
        do_reset();
        wr_en   = 1'b1;
        wr_data = 32'h10;
        tick();
        for (int i = 0; i < 9; i++) begin
            wr_data = 32'h20 + 32'(i);
            tick();
        end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        wr_data   = 32'h29;
        clear_ovf = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count2: got %0d expected 8", fifo_count); end
        wr_en = 1'b0;
        tick();
        clear_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
        repeat (FRAME - 10) tick();
        for (int f = 0; f < 8; f++) begin
            capture_frame(d, par, stp, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL ovf_frame%0d_timeout: got 1 expected 0", f); end
            checks++; if (d !== 8'(8'h20 + f)) begin errors++; $display("FAIL ovf_frame%0d_data: got %02h expected %02h", f, d, 8'(8'h20 + f)); end
            checks++; if (stp !== 1'b1) begin errors++; $display("FAIL ovf_frame%0d_stop: got %b expected 1", f, stp); end
`ifdef OUTPORT_UART_TX_PARITY_EN
            checks++; if (par !== ^(8'(8'h20 + f))) begin errors++; $display("FAIL ovf_frame%0d_par: got %b expected %b", f, par, ^(8'(8'h20 + f))); end
`endif
            $display("overflow test frame %0d: byte %02h", f, d);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_end_busy: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_end_empty: got %b expected 1", empty); end
        repeat (2 * CPB) tick();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ovf_no_extra: got %b expected 1", tx); end
    endtask

    task automatic test_full_pop_write();
        logic [7:0] d;
        logic par;
        logic stp;
        bit   to;
        do_reset();
        wr_en   = 1'b1;
        wr_data = 32'h30;
        tick();
        for (int i = 0; i < 8; i++) begin
            wr_data = 32'h50 + 32'(i);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpw_full: got %b expected 1", full); end
        repeat (FRAME - 1 - 7) tick();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fpw_full_pre: got %b expected 1", full); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL fpw_stop_tx: got %b expected 1", tx); end
        wr_data = 32'h58;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fpw_count: got %0d expected 8", fifo_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpw_ovf: got %b expected 0", overflow); end
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL fpw_start_tx: got %b expected 0", tx); end
        for (int f = 0; f < 9; f++) begin
            capture_frame(d, par, stp, to);
            checks++; if (to !== 1'b0) begin errors++; $display("FAIL fpw_frame%0d_timeout: got 1 expected 0", f); end
            checks++; if (d !== 8'(8'h50 + f)) begin errors++; $display("FAIL fpw_frame%0d_data: got %02h expected %02h", f, d, 8'(8'h50 + f)); end
            checks++; if (stp !== 1'b1) begin errors++; $display("FAIL fpw_frame%0d_stop: got %b expected 1", f, stp); end
            $display("full-pop test frame %0d: byte %02h", f, d);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fpw_end_empty: got %b expected 1", empty); end
    endtask

    task automatic test_reset_mid_frame();
        int lows;
        int busies;
        do_reset();
        wr_en   = 1'b1;
        wr_data = 32'hFF;
        tick();
        wr_data = 32'h11;
        tick();
        wr_data = 32'h22;
        tick();
        wr_en = 1'b0;
        repeat (16) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmf_busy_pre: got %b expected 1", busy); end
        checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL rmf_count_pre: got %0d expected 2", fifo_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rmf_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmf_busy: got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rmf_empty: got %b expected 1", empty); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rmf_count: got %0d expected 0", fifo_count); end
        lows   = 0;
        busies = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL rmf_quiet_tx: got %0d low cycles expected 0", lows); end
        checks++; if (busies !== 0) begin errors++; $display("FAIL rmf_quiet_busy: got %0d busy cycles expected 0", busies); end
        $display("reset mid-frame: line quiet afterwards");
    endtask

    task automatic test_upper_bits();
        logic [7:0] d;
        logic par;
        logic stp;
        bit   to;
        do_reset();
        wr_data = 32'h1234_5600;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        wr_data = 32'hFFFF_FFFF;
        capture_frame(d, par, stp, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL upper_timeout: got 1 expected 0"); end
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL upper_data: got %02h expected 00", d); end
        checks++; if (stp !== 1'b1) begin errors++; $display("FAIL upper_stop: got %b expected 1", stp); end
`ifdef OUTPORT_UART_TX_PARITY_EN
        checks++; if (par !== 1'b0) begin errors++; $display("FAIL upper_par: got %b expected 0", par); end
`endif
        $display("upper-bits test: byte %02h", d);
    endtask

    initial begin
        reset     = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 32'h0;
        clear_ovf = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_full_pop_write();
        test_reset_mid_frame();
        test_upper_bits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
